mac_operand_sequencer: RTL and testbench

Drives a traditional or Booth-based `mac` instance with operand pairs and collects its accumulated result. Operand pairs arrive over a valid/ready stream into a small FIFO. They are issued to the MAC in dot-product vectors of VEC_LEN terms, with the MAC cleared between vectors. Each final accumulator value is returned over a valid/ready result stream. It is the producer/consumer end of the MAC's `a`/`b`/`rst`/`out` interface, replacing bench-driven stimulus in integrated datapaths.

---
 rtl/mac_operand_sequencer_if.sv | 29 ++
 rtl/mac_operand_sequencer.sv | 149 ++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_sequencer_if.sv
// Stream and MAC-side signals of the operand sequencer, grouped for port connection.
// The slave modport is the sequencer's view; master is the environment's view.
interface mac_operand_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_a;
  logic signed [DATA_WIDTH-1:0] in_b;
  logic                         mac_clr;
  logic signed [DATA_WIDTH-1:0] mac_a;
  logic signed [DATA_WIDTH-1:0] mac_b;
  logic signed [OUT_WIDTH-1:0]  mac_out;
  logic                         res_valid;
  logic                         res_ready;
  logic signed [OUT_WIDTH-1:0]  res_data;
  logic                         busy;

  modport slave (
    input  in_valid, in_a, in_b, mac_out, res_ready,
    output in_ready, mac_clr, mac_a, mac_b, res_valid, res_data, busy
  );

  modport master (
    output in_valid, in_a, in_b, mac_out, res_ready,
    input  in_ready, mac_clr, mac_a, mac_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Feeds a MAC with VEC_LEN-term dot products from a small operand FIFO,
// clearing it between vectors and returning each accumulated result.
module mac_operand_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int VEC_LEN    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAC_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mac_operand_sequencer_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int DW = $clog2(MAC_LAT + 1);

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] a;
    logic signed [DATA_WIDTH-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_e;

  pair_t         mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          push, pop, empty, full;
  pair_t         head;

  state_e                       state_q, state_d;
  logic [CW-1:0]                term_q, term_d;
  logic [DW-1:0]                drn_q, drn_d;
  logic signed [DATA_WIDTH-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic                         mac_clr_q, mac_clr_d;
  logic                         res_valid_q, res_valid_d;
  logic signed [OUT_WIDTH-1:0]  res_data_q, res_data_d;

  // in_ready depends on the occupancy count alone
  assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = bus.in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: bus.in_a, b: bus.in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      term_q      <= '0;
      drn_q       <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clr_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      term_q      <= term_d;
      drn_q       <= drn_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_clr_q   <= mac_clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Operands are registered, so the last pair sits on the bus during the first
  // DRAIN cycle; DRAIN therefore spans MAC_LAT+1 cycles before capture.
  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    drn_d       = drn_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_clr_d   = 1'b1;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          mac_a_d   = head.a;
          mac_b_d   = head.b;
          mac_clr_d = 1'b0;
          term_d    = CW'(1);
          drn_d     = '0;
          state_d   = (VEC_LEN == 1) ? DRAIN : FEED;
        end
      end
      FEED: begin
        mac_clr_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          mac_a_d = head.a;
          mac_b_d = head.b;
          term_d  = term_q + CW'(1);
          if (term_q == CW'(VEC_LEN - 1)) begin
            drn_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        mac_clr_d = 1'b0;
        if (drn_q == DW'(MAC_LAT)) begin
          res_data_d  = bus.mac_out;
          res_valid_d = 1'b1;
          mac_clr_d   = 1'b1;
          state_d     = HOLD;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          term_d      = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = !full;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q == FEED) || (state_q == DRAIN);
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: a latency-1 MAC model, table-driven vectors,
// hand-written backpressure/reset sequences and a randomized scoreboard phase.
module tb_mac_operand_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_operand_sequencer_if #(.DATA_WIDTH(16), .OUT_WIDTH(32)) bus ();

  mac_operand_sequencer #(
    .DATA_WIDTH(16), .OUT_WIDTH(32), .VEC_LEN(4), .FIFO_DEPTH(4), .MAC_LAT(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Traditional MAC: synchronous clear, one-cycle accumulate
  always_ff @(posedge clk) begin
    if (bus.mac_clr) bus.mac_out <= '0;
    else             bus.mac_out <= bus.mac_out + 32'(bus.mac_a) * 32'(bus.mac_b);
  end

  typedef struct packed {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [7:0]       gap;
    logic [31:0]      exp;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input int a0, b0, a1, b1, a2, b2, a3, b3, gap,
                              input logic [31:0] e);
    vec_t v;
    v.a   = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    v.b   = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    v.gap = 8'(gap);
    v.exp = e;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_mac_clr"},   32'(bus.mac_clr), 32'd1);
    check({tag, "_mac_a"},     {16'h0, bus.mac_a}, 32'd0);
    check({tag, "_mac_b"},     {16'h0, bus.mac_b}, 32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_res_data"},  bus.res_data, 32'd0);
    check({tag, "_busy"},      32'(bus.busy), 32'd0);
  endtask

  task automatic push_pair(input int a, input int b);
    bus.in_valid = 1'b1;
    bus.in_a = 16'(a);
    bus.in_b = 16'(b);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res();
    for (int i = 0; i < 60 && !bus.res_valid; i++) begin
      @(posedge clk); #1;
    end
    check("res_timeout", 32'(bus.res_valid), 32'd1);
  endtask

  // Runs one vector from an empty idle block with res_ready high; edge 0 is the first push.
  task automatic run_vec(input vec_t v, input string tag);
    int g, rise, last;
    logic [15:0] oa [64];
    logic [15:0] ob [64];
    logic clr0, clr1;
    g = int'(v.gap) + 1;
    rise = -1;
    clr0 = 1'b0;
    clr1 = 1'b1;
    for (int e = 0; e < 64 && rise < 0; e++) begin
      if (e % g == 0 && e / g < 4) begin
        bus.in_valid = 1'b1;
        bus.in_a = v.a[e / g];
        bus.in_b = v.b[e / g];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      oa[e] = bus.mac_a;
      ob[e] = bus.mac_b;
      if (e == 0) clr0 = bus.mac_clr;
      if (e == 1) clr1 = bus.mac_clr;
      if (bus.res_valid) rise = e;
    end
    bus.in_valid = 1'b0;
    last = 3 * g + 1;
    check({tag, "_rise_edge"}, 32'(rise), 32'(last + 2));
    check({tag, "_res_data"}, bus.res_data, v.exp);
    check({tag, "_clr_before"}, 32'(clr0), 32'd1);
    check({tag, "_clr_launch"}, 32'(clr1), 32'd0);
    if (rise > 0) begin
      for (int e = 1; e <= last; e++) begin
        logic [15:0] ea, eb;
        ea = ((e - 1) % g == 0) ? v.a[(e - 1) / g] : 16'h0;
        eb = ((e - 1) % g == 0) ? v.b[(e - 1) / g] : 16'h0;
        check($sformatf("%s_mac_a_e%0d", tag, e), {16'h0, oa[e]}, {16'h0, ea});
        check($sformatf("%s_mac_b_e%0d", tag, e), {16'h0, ob[e]}, {16'h0, eb});
      end
    end
    @(posedge clk); #1;
    check({tag, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  vec_t tbl [6];
  logic [31:0] exp_q [$];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b1;

    tbl[0] = mk(15, 5, 10, 29, 7, 5, 3, -2, 0, 32'd394);
    tbl[1] = mk(-6, 6, -2, -2, 0, 0, 0, 0, 0, 32'hFFFF_FFE0);
    tbl[2] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 0, 32'd0);
    tbl[3] = mk(15, 5, 10, 29, 7, 5, 3, -2, 2, 32'd394);
    tbl[4] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 1, 32'hFFFC_0004);
    tbl[5] = mk(1, 1, 2, 2, 3, 3, 4, 4, 1, 32'd30);

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Backpressure: result held while the next vector fills the FIFO
    bus.res_ready = 1'b0;
    push_pair(15, 5); push_pair(10, 29); push_pair(7, 5); push_pair(3, -2);
    wait_res();
    for (int k = 0; k < 12; k++) begin
      if (k < 4) push_pair(2 * k + 1, 2 * k + 2);
      else begin @(posedge clk); #1; end
      check($sformatf("bp_res_valid_%0d", k), 32'(bus.res_valid), 32'd1);
      check($sformatf("bp_res_data_%0d", k), bus.res_data, 32'd394);
      check($sformatf("bp_mac_clr_%0d", k), 32'(bus.mac_clr), 32'd1);
      if (k >= 3) check($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released", 32'(bus.res_valid), 32'd0);
    wait_res();
    check("bp_second_res", bus.res_data, 32'd100);
    @(posedge clk); #1;

    // Reset mid-FEED: two launched, one queued
    push_pair(15, 5); push_pair(10, 29); push_pair(7, 5);
    check("midfeed_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_busy", 32'(bus.busy), 32'd0);
    check("postrst_mac_a", {16'h0, bus.mac_a}, 32'd0);
    check("postrst_clr", 32'(bus.mac_clr), 32'd1);
    run_vec(tbl[0], "postrst");

    // Randomized traffic against a sum-of-products scoreboard
    fork
      begin : producer
        logic [31:0] sum;
        logic signed [15:0] ra, rb;
        int pushed, guard;
        sum = '0;
        pushed = 0;
        guard = 0;
        while (pushed < 24 && guard < 3000) begin
          bus.in_valid = ($urandom % 3) != 0;
          if (bus.in_valid) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            bus.in_a = ra;
            bus.in_b = rb;
            if (bus.in_ready) begin
              sum = sum + 32'(int'(ra) * int'(rb));
              pushed++;
              if (pushed % 4 == 0) begin
                exp_q.push_back(sum);
                sum = '0;
              end
            end
          end
          @(posedge clk); #1;
          guard++;
        end
        bus.in_valid = 1'b0;
      end
      begin : consumer
        int got, cyc;
        logic [31:0] e;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 3000) begin
          bus.res_ready = ($urandom % 2) != 0;
          if (bus.res_valid && bus.res_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : ~bus.res_data;
            check($sformatf("rand_res_%0d", got), bus.res_data, e);
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        check("rand_count", 32'(got), 32'd6);
        bus.res_ready = 1'b1;
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
